dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signals of the two-port data memory arbiter
interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0, req1;
  logic             we0, we1;
  logic [WIDTH-1:0] addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             done0, done1;
  logic             err0, err1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             mem_re, mem_wr;
  logic [WIDTH-1:0] mem_addr, mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
    output mem_re, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
    input  mem_re, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter in front of a single-port data memory
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MEM_SIZE = 1024
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic             last;
  logic             win;
  logic             inr;
  logic             gnt0_q, gnt1_q, done0_q, done1_q, err0_q, err1_q;
  logic             mem_re_q, mem_wr_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic [WIDTH-1:0] rdata0_q, rdata1_q;

  logic             pick;
  logic             sel_we;
  logic [WIDTH-1:0] sel_addr, sel_wdata;
  logic             sel_inr;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    pick      = (bus.req0 && bus.req1) ? ~last : bus.req1;
    sel_we    = pick ? bus.we1    : bus.we0;
    sel_addr  = pick ? bus.addr1  : bus.addr0;
    sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    sel_inr   = 64'(sel_addr) < 64'(MEM_SIZE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      win         <= 1'b0;
      inr         <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state       <= ACCESS;
            last        <= pick;
            win         <= pick;
            inr         <= sel_inr;
            gnt0_q      <= ~pick;
            gnt1_q      <= pick;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_wr_q    <= sel_we & sel_inr;
            mem_re_q    <= ~sel_we & sel_inr;
          end
        end
        ACCESS: begin
          state       <= RESP;
          gnt0_q      <= 1'b0;
          gnt1_q      <= 1'b0;
          mem_re_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          done0_q     <= ~win;
          done1_q     <= win;
          err0_q      <= ~win & ~inr;
          err1_q      <= win & ~inr;
          // Out-of-range accesses of either kind clear the winner's read result.
          if (!inr) begin
            if (win) rdata1_q <= '0;
            else     rdata0_q <= '0;
          end else if (mem_re_q) begin
            if (win) rdata1_q <= bus.mem_rdata;
            else     rdata0_q <= bus.mem_rdata;
          end
        end
        RESP: begin
          state   <= IDLE;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int W  = 32;
  localparam int MS = 1024;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  dmem_arbiter_if #(.WIDTH(W)) bus ();

  dmem_arbiter #(.WIDTH(W), .MEM_SIZE(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Attached memory driven only by the DUT strobes.
  logic [W-1:0] tb_mem [MS];
  always_comb bus.mem_rdata = bus.mem_re ? tb_mem[bus.mem_addr[9:0]] : '0;
  always @(posedge clk) if (bus.mem_wr) tb_mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

  // Reference model state.
  logic [W-1:0] ref_mem [MS];
  logic [W-1:0] ref_rdata [2];
  bit           ref_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " gnt"},  {62'd0, bus.gnt0, bus.gnt1}, 64'd0);
    check({tag, " done"}, {62'd0, bus.done0, bus.done1}, 64'd0);
    check({tag, " err"},  {62'd0, bus.err0, bus.err1}, 64'd0);
    check({tag, " strobes"}, {62'd0, bus.mem_re, bus.mem_wr}, 64'd0);
    check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
  endtask

  // One complete transaction; called just after a falling edge with the DUT idle.
  task automatic txn(input bit r0, input bit r1, input bit w0, input bit w1,
                     input logic [W-1:0] a0, input logic [W-1:0] a1,
                     input logic [W-1:0] d0, input logic [W-1:0] d1);
    bit           w, we, inr;
    logic [W-1:0] a, d;
    bus.req0 = r0; bus.req1 = r1; bus.we0 = w0; bus.we1 = w1;
    bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
    w   = (r0 && r1) ? !ref_last : r1;
    we  = w ? w1 : w0;
    a   = w ? a1 : a0;
    d   = w ? d1 : d0;
    inr = a < MS;
    @(negedge clk);
    check("gnt0", 64'(bus.gnt0), 64'(!w));
    check("gnt1", 64'(bus.gnt1), 64'(w));
    check("access strobes", {62'd0, bus.mem_re, bus.mem_wr}, {62'd0, !we && inr, we && inr});
    check("mem_addr", 64'(bus.mem_addr), 64'(a));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(d));
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    ref_last = w;
    if (we && inr) ref_mem[a[9:0]] = d;
    if (!inr) ref_rdata[w] = '0;
    else if (!we) ref_rdata[w] = ref_mem[a[9:0]];
    @(negedge clk);
    check("done", {62'd0, bus.done0, bus.done1}, {62'd0, !w, w});
    check("err", {62'd0, bus.err0, bus.err1}, {62'd0, !w && !inr, w && !inr});
    check("resp gnt", {62'd0, bus.gnt0, bus.gnt1}, 64'd0);
    check("resp strobes", {62'd0, bus.mem_re, bus.mem_wr}, 64'd0);
    check("rdata0", 64'(bus.rdata0), 64'(ref_rdata[0]));
    check("rdata1", 64'(bus.rdata1), 64'(ref_rdata[1]));
    @(negedge clk);
    check_quiet("idle");
  endtask

  initial begin
    bit           r0, r1, exp0, exp1;
    logic [W-1:0] a0, a1;
    int           seen_done;
    for (int i = 0; i < MS; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1'b1;
    reset = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset rdata", {bus.rdata0, bus.rdata1}, 64'd0);

    // Both ports requesting continuously out of reset: grants alternate 0,1,0,1 every 3 cycles.
    tb_mem[7] = 32'h0000_0777; ref_mem[7] = 32'h0000_0777;
    tb_mem[8] = 32'h0000_0888; ref_mem[8] = 32'h0000_0888;
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 7; bus.addr1 = 8;
    reset = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      exp0 = (cyc % 3 == 1) && ((cyc / 3) % 2 == 0);
      exp1 = (cyc % 3 == 1) && ((cyc / 3) % 2 == 1);
      check("rr gnt", {62'd0, bus.gnt0, bus.gnt1}, {62'd0, exp0, exp1});
    end
    bus.req0 = 0; bus.req1 = 0;
    ref_last = 1'b1; ref_rdata[0] = ref_mem[7]; ref_rdata[1] = ref_mem[8];
    check("rr rdata0", 64'(bus.rdata0), 64'(ref_rdata[0]));
    check("rr rdata1", 64'(bus.rdata1), 64'(ref_rdata[1]));
    @(negedge clk);

    // Write then read back through port 0.
    txn(1, 0, 1, 0, 32'd5, 32'd0, 32'hDEAD_BEEF, 32'd0);
    txn(1, 0, 0, 0, 32'd5, 32'd0, 32'd0, 32'd0);
    // Port 1 read just past the end of memory.
    txn(0, 1, 0, 0, 32'd0, 32'd1024, 32'd0, 32'd0);
    // Last valid word, written by port 1 then read by port 0.
    txn(0, 1, 0, 1, 32'd0, 32'd1023, 32'd0, 32'h1234_5678);
    txn(1, 0, 0, 0, 32'd1023, 32'd0, 32'd0, 32'd0);
    // Out-of-range write and a huge address.
    txn(1, 0, 1, 0, 32'hFFFF_FFFF, 32'd0, 32'h5555_AAAA, 32'd0);

    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r1 = 1'b1;
      a0 = ($urandom_range(0, 7) == 0) ? 32'(1020 + $urandom_range(0, 10)) : 32'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 7) == 0) ? 32'(1020 + $urandom_range(0, 10)) : 32'($urandom_range(0, 15));
      txn(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0, a1, $urandom, $urandom);
    end

    // Reset in the middle of a write access: strobe drops without a clock edge, no done.
    txn(1, 0, 1, 0, 32'd20, 32'd0, 32'hCAFE_0020, 32'd0);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 20; bus.wdata0 = 32'hBAD0_BAD0;
    @(negedge clk);
    check("pre-reset mem_wr", 64'(bus.mem_wr), 64'd1);
    #2 reset = 1'b1;
    bus.req0 = 0;
    #1;
    check("async mem_wr", 64'(bus.mem_wr), 64'd0);
    check("async gnt0", 64'(bus.gnt0), 64'd0);
    check("async mem_addr", 64'(bus.mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_last = 1'b1; ref_rdata[0] = '0; ref_rdata[1] = '0;
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      seen_done += int'(bus.done0) + int'(bus.done1);
    end
    check("no done after reset", 64'(seen_done), 64'd0);
    check("post-reset rdata", {bus.rdata0, bus.rdata1}, 64'd0);
    txn(1, 0, 0, 0, 32'd20, 32'd0, 32'd0, 32'd0);
    txn(1, 1, 0, 0, 32'd5, 32'd1023, 32'd0, 32'd0);
    txn(1, 1, 0, 0, 32'd5, 32'd1023, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
